// File: rtl/mdu_seq_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface mdu_seq_if;
    logic        StartE;
    logic [2:0]  MdOpE;
    logic        FlushE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MdBusyE;
    logic        MdDoneE;
    logic [31:0] MdResultE;

    modport master (
        output StartE, MdOpE, FlushE, SrcAE, SrcBE,
        input  MdBusyE, MdDoneE, MdResultE
    );

    modport slave (
        input  StartE, MdOpE, FlushE, SrcAE, SrcBE,
        output MdBusyE, MdDoneE, MdResultE
    );
endinterface

// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer: radix-2 shift-add / restoring divide, one step per cycle,
// stalling Execute while it iterates.
module mdu_seq (
    input  logic       clk,
    input  logic       reset,
    mdu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg;
    logic [2:0]  op_reg;
    logic [31:0] opnd_reg;
    logic [63:0] acc_reg;
    logic        sign_q_reg;
    logic        sign_r_reg;
    logic [31:0] result_reg;

    logic        start_ok;
    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        is_div, div_zero, div_ovf, special;
    logic [31:0] special_res;

    assign start_ok = bus.StartE & ~bus.FlushE;

    // Operand signedness by funct3: MUL/MULH/DIV/REM both signed, MULHSU only rs1.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.MdOpE)
            3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'd2:                   a_signed = 1'b1;
            default:                ;
        endcase
    end

    assign a_neg  = a_signed & bus.SrcAE[31];
    assign b_neg  = b_signed & bus.SrcBE[31];
    assign a_mag  = a_neg ? (~bus.SrcAE + 32'd1) : bus.SrcAE;
    assign b_mag  = b_neg ? (~bus.SrcBE + 32'd1) : bus.SrcBE;

    assign is_div   = bus.MdOpE[2];
    assign div_zero = (bus.SrcBE == 32'd0);
    assign div_ovf  = ~bus.MdOpE[0] & (bus.SrcAE == 32'h8000_0000) & (bus.SrcBE == 32'hFFFF_FFFF);
    assign special  = is_div & (div_zero | div_ovf);

    always_comb begin
        if (div_zero)
            special_res = bus.MdOpE[1] ? bus.SrcAE : 32'hFFFF_FFFF;
        else
            special_res = bus.MdOpE[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply: acc = {partial_hi, multiplier}; add multiplicand on the LSB, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    assign mul_step = {mul_sum, acc_reg[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract divisor.
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_step;
    assign rem_sh   = {acc_reg[63:32], acc_reg[31]};
    assign div_ge   = (rem_sh >= {1'b0, opnd_reg});
    assign div_diff = rem_sh[31:0] - opnd_reg;
    assign div_step = {(div_ge ? div_diff : rem_sh[31:0]), acc_reg[30:0], div_ge};

    logic [63:0] acc_step, prod_s;
    logic [31:0] quo_s, rem_s, final_res;
    assign acc_step = op_reg[2] ? div_step : mul_step;
    assign prod_s   = sign_q_reg ? (~acc_step + 64'd1) : acc_step;
    assign quo_s    = sign_q_reg ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    assign rem_s    = sign_r_reg ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];

    always_comb begin
        case (op_reg)
            3'd0:       final_res = prod_s[31:0];
            3'd1, 3'd2,
            3'd3:       final_res = prod_s[63:32];
            3'd4, 3'd5: final_res = quo_s;
            default:    final_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    logic busy_int, done_int;

    always_comb begin
        state_next = state_reg;
        busy_int   = 1'b0;
        done_int   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    busy_int   = 1'b1;
                    state_next = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.FlushE) begin
                    state_next = IDLE;
                end else begin
                    busy_int = 1'b1;
                    if (cnt_reg == 6'd31)
                        state_next = DONE;
                end
            end
            DONE: begin
                done_int   = ~bus.FlushE;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate with reset so the stall drops the instant reset is asserted, whatever StartE does.
    assign bus.MdBusyE   = busy_int & reset;
    assign bus.MdDoneE   = done_int & reset;
    assign bus.MdResultE = result_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg    <= 6'd0;
            op_reg     <= 3'd0;
            opnd_reg   <= 32'd0;
            acc_reg    <= 64'd0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            result_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        op_reg     <= bus.MdOpE;
                        cnt_reg    <= 6'd0;
                        sign_q_reg <= a_neg ^ b_neg;
                        sign_r_reg <= a_neg;
                        if (is_div) begin
                            opnd_reg <= b_mag;
                            acc_reg  <= {32'd0, a_mag};
                        end else begin
                            opnd_reg <= a_mag;
                            acc_reg  <= {32'd0, b_mag};
                        end
                        if (special)
                            result_reg <= special_res;
                    end
                end
                CALC: begin
                    if (!bus.FlushE) begin
                        acc_reg <= acc_step;
                        cnt_reg <= cnt_reg + 6'd1;
                        if (cnt_reg == 6'd31)
                            result_reg <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
